swap_loader: RTL
================

// Module: swap_loader
// PURPOSE
//  Upstream sequencer for the 3-register bus swap unit. Accepts three words over a
//  valid/ready stream and writes them into R1, R2, R3 through the external tri-state
//  path (Data/Extern/RinExtk). It then pulses w to start the swap and waits for Done.
//  It reports completion, keeps a count of finished swaps, and flags a timeout if Done never arrives.
// PARAMETERS
//  N        8   data / bus width
//  TIMEOUT  8   max WAIT cycles without Done before ERR (>=4)
// PORTS
//  Clock     in   1  clock; all state changes on posedge
//  Resetn    in   1  reset, asynchronous, active-low
//  in_valid  in   1  upstream word valid
//  in_ready  out  1  loader accepts word this cycle
//  in_data   in   N  upstream word
//  Data      out  N  word to swap unit external tri-state
//  Extern    out  1  enable external driver onto BusWires
//  RinExt1   out  1  load R1 from bus (RinExt2/RinExt3 same, 1 bit each, for R2/R3)
//  w         out  1  start-swap request to swap unit
//  Done      in   1  swap unit final-step indicator
//  Complete  out  1  one-cycle pulse: swap finished
//  Error     out  1  high while in ERR (timeout)
//  err_clr   in   1  leave ERR
//  SwapCnt   out  8  completed-swap count, wraps 255->0
// BEHAVIOUR
//  States: LOAD1, LOAD2, LOAD3, GO, WAIT, FIN, ERR. Reset state LOAD1.
//  Reset (async, any state): state=LOAD1; Data=0; Extern=RinExt1..3=0; w=0;
//   Complete=0; Error=0; SwapCnt=0; timeout counter=0. Bus is released immediately.
//  in_ready = 1 in LOAD1..LOAD3 only (Moore; no dependence on in_valid).
//  Accept = in_valid & in_ready. On accept in LOADk: Data<=in_data; Extern<=1;
//   RinExtk<=1 (registered); advance LOADk->LOAD(k+1), or LOAD3->GO.
//  Drive pulses last exactly the one cycle after the accept edge, then clear.
//   Back-to-back accepts give back-to-back pulses. Only one RinExtk is high at a time.
//  No accept in LOADk: hold state. Extern/RinExt stay 0. Data holds its last value.
//  GO: w=1 for exactly this cycle (the R3 drive pulse is also active here). Next: WAIT, cnt=0.
//  WAIT: w=0. Done=1 -> FIN. Else if cnt==TIMEOUT-1 -> ERR. Else cnt++.
//  FIN: Complete=1 (this cycle only); SwapCnt++ mod 256; next LOAD1.
//  ERR: Error=1, in_ready=0, all drive outputs 0. err_clr=1 -> LOAD1.
//   Resetn also exits ERR. SwapCnt is not changed by ERR.
//  Done outside WAIT is ignored.
//  Extern is never 1 in WAIT/FIN/ERR, so there is no bus contention with the swap unit's drivers.
//  Latency, stall-free with a conforming swap unit: accepts at t, t+1, t+2.
//   GO at t+3; WAIT t+4..t+6 (Done at t+6); Complete at t+7; in_ready again at t+8.
//  Complete, Error, w, in_ready decode from state. Data/Extern/RinExtk are flops.
// TESTING
//  1 Hold Resetn=0 then release -> all outputs 0, SwapCnt=0, in_ready=1 in first cycle.
//  2 Swap model + words 0x11,0x22,0x33 back-to-back -> RinExt1/2/3 pulses carry
//    Data=0x11/0x22/0x33 on consecutive cycles. w one cycle. Complete 4 cycles after w.
//    Model ends with R1=0x22, R2=0x11, R3=0x22. SwapCnt=1.
//  3 in_valid low 3 cycles between words 1 and 2 -> state held, no Extern/RinExt pulses
//    during gap, same final result as test 2.
//  4 Done tied 0 -> Error=1 after exactly 8 WAIT cycles, in_ready=0, Extern=0.
//    err_clr=1 -> LOAD1, Error=0, SwapCnt unchanged.
//  5 Resetn pulsed low during WAIT (and during a RinExt2 pulse) -> outputs 0 with no
//    clock edge. Next load sequence starts at LOAD1 and completes normally.
//  6 Run 256 swaps -> SwapCnt reads 0xFF after 255 and wraps to 0x00 after 256.

Source files
------------

// File: rtl/swap_loader.sv
// swap_loader: upstream sequencer for the 3-register bus swap unit.
// Takes three words over a valid/ready stream and writes them into R1/R2/R3
// through the external tri-state path. It then requests a swap with w and
// waits for Done. Completion is reported with Complete and counted in SwapCnt.
// A missing Done is reported by raising Error until err_clr is asserted.
module swap_loader #(
  parameter int N       = 8,
  parameter int TIMEOUT = 8
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic [N-1:0] Data,
  output logic         Extern,
  output logic         RinExt1,
  output logic         RinExt2,
  output logic         RinExt3,
  output logic         w,
  input  logic         Done,
  output logic         Complete,
  output logic         Error,
  input  logic         err_clr,
  output logic [7:0]   SwapCnt
);

  // The WAIT counter only has to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [2:0] {
    LOAD1 = 3'd0,
    LOAD2 = 3'd1,
    LOAD3 = 3'd2,
    GO    = 3'd3,
    WAIT  = 3'd4,
    FIN   = 3'd5,
    ERR   = 3'd6
  } state_t;

  state_t        state_r;
  state_t        next_state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic          accept_s;

  // A word is taken only in a LOAD state when upstream presents one.
  assign accept_s = in_valid & in_ready;

  // State and WAIT timeout counter registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r <= LOAD1;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state logic and the Moore outputs that decode from the state.
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r;
    in_ready     = 1'b0;
    w            = 1'b0;
    Complete     = 1'b0;
    Error        = 1'b0;
    case (state_r)
      LOAD1: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state_s = LOAD2;
        end else begin
          next_state_s = LOAD1;
        end
      end
      LOAD2: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state_s = LOAD3;
        end else begin
          next_state_s = LOAD2;
        end
      end
      LOAD3: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state_s = GO;
        end else begin
          next_state_s = LOAD3;
        end
      end
      GO: begin
        // The R3 drive pulse is still on the bus during this cycle.
        w            = 1'b1;
        next_state_s = WAIT;
        cnt_next_s   = CNT_ZERO;
      end
      WAIT: begin
        if (Done) begin
          next_state_s = FIN;
        end else if (cnt_r == CNT_LAST) begin
          next_state_s = ERR;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      FIN: begin
        Complete     = 1'b1;
        next_state_s = LOAD1;
      end
      ERR: begin
        Error = 1'b1;
        if (err_clr) begin
          next_state_s = LOAD1;
        end else begin
          next_state_s = ERR;
        end
      end
      default: begin
        next_state_s = LOAD1;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  // Bus drive flops. Each accept produces a single-cycle Extern and RinExtk pulse.
  // Data keeps the last accepted word between accepts.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Data    <= '0;
      Extern  <= 1'b0;
      RinExt1 <= 1'b0;
      RinExt2 <= 1'b0;
      RinExt3 <= 1'b0;
    end else begin
      Extern  <= 1'b0;
      RinExt1 <= 1'b0;
      RinExt2 <= 1'b0;
      RinExt3 <= 1'b0;
      if (accept_s) begin
        Data   <= in_data;
        Extern <= 1'b1;
        case (state_r)
          LOAD1:   RinExt1 <= 1'b1;
          LOAD2:   RinExt2 <= 1'b1;
          LOAD3:   RinExt3 <= 1'b1;
          default: Extern  <= 1'b0;
        endcase
      end
    end
  end

  // Completed-swap counter. It advances once per FIN and wraps modulo 256.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      SwapCnt <= 8'd0;
    end else if (state_r == FIN) begin
      SwapCnt <= SwapCnt + 8'd1;
    end
  end

endmodule
